// File: rtl/digi_ota_pkg.sv
`default_nettype none
// ============================================================================
// Module : digi_ota_pkg
// Brief  : Shared types, default parameter values and the saturation helper
//          for the sampled digital OTA core.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Contents
//   DEF_*     default parameter values used by digi_ota_sampled_core
//   SAT_W     working width of the saturate() helper
//   mode_e    operating mode of the output node
//   saturate  clamp a signed value to the range of a w-bit signed number
// ============================================================================
package digi_ota_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_ACC_W    = 12;
   localparam int DEF_GM_SHIFT = 2;
   localparam int DEF_HYST     = 4;
   localparam int DEF_DEBOUNCE = 3;

   // The helper works on a fixed wide word so that it can be shared by any
   // instance regardless of its ACC_W; callers sign-extend into it.
   localparam int SAT_W = 32;

   typedef enum logic [1:0] {
      MODE_CMP    = 2'b00,
      MODE_INTEG  = 2'b01,
      MODE_FOLLOW = 2'b10
   } mode_e;

   // Clamp x to [-2^(w-1), 2^(w-1)-1]. w must be in 2..SAT_W-1.
   function automatic logic signed [SAT_W-1:0] saturate(
      input logic signed [SAT_W-1:0] x,
      input int                      w
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (x > hi) begin
         return hi;
      end else if (x < lo) begin
         return lo;
      end else begin
         return x;
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/digi_ota_hyst_cmp.sv
`default_nettype none
// ============================================================================
// Module : digi_ota_hyst_cmp
// Brief  : Hysteretic, debounced comparator on the output-node level.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1      clock
//   rst_n     in   1      asynchronous reset, active low
//   clr       in   1      synchronous clear of target, count and output
//   upd       in   1      a new level is presented this cycle
//   mode_chg  in   1      the sample being applied changed the operating mode
//   level     in   ACC_W  new output-node level (signed)
//   out_cmp   out  1      debounced comparator output
// ============================================================================
module digi_ota_hyst_cmp #(
   parameter int ACC_W    = 12,
   parameter int HYST     = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    upd,
   input  logic                    mode_chg,
   input  logic signed [ACC_W-1:0] level,
   output logic                    out_cmp
);

   localparam int                      c_cnt_w   = $clog2(DEBOUNCE + 1);
   localparam logic signed [ACC_W-1:0] c_hyst_hi = ACC_W'(HYST);
   localparam logic signed [ACC_W-1:0] c_hyst_lo = -c_hyst_hi;
   localparam logic [c_cnt_w-1:0]      c_deb     = c_cnt_w'(DEBOUNCE);

   logic               r_target;
   logic               r_cmp;
   logic [c_cnt_w-1:0] r_cnt;
   logic               w_target;
   logic [c_cnt_w-1:0] w_cnt_inc;

   // Inside the dead band [-HYST, +HYST] the previous target is kept.
   always_comb begin
      w_target = r_target;
      if (level > c_hyst_hi) begin
         w_target = 1'b1;
      end else if (level < c_hyst_lo) begin
         w_target = 1'b0;
      end
   end

   assign w_cnt_inc = r_cnt + c_cnt_w'(1);

   // The target is cleared together with the output so that a cleared block
   // starts from a consistent "low" state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_target <= 1'b0;
         r_cmp    <= 1'b0;
         r_cnt    <= '0;
      end else if (clr) begin
         r_target <= 1'b0;
         r_cmp    <= 1'b0;
         r_cnt    <= '0;
      end else if (upd) begin
         r_target <= w_target;
         if (mode_chg) begin
            // A sample in a new mode restarts the agreement count.
            r_cnt <= '0;
         end else if (w_target != r_cmp) begin
            if (w_cnt_inc == c_deb) begin
               r_cmp <= w_target;
               r_cnt <= '0;
            end else begin
               r_cnt <= w_cnt_inc;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign out_cmp = r_cmp;

endmodule
`default_nettype wire

// File: rtl/digi_ota_sampled_core.sv
`default_nettype none
// ============================================================================
// Module : digi_ota_sampled_core
// Brief  : Clocked digital OTA. Two-stage pipeline taking differential
//          samples and producing an output-node level (comparator,
//          integrator or slew-limited follower) plus a debounced comparator.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      clock
//   rst_n      in   1      asynchronous reset, active low
//   en         in   1      block enable, gates in_ready
//   clr        in   1      synchronous clear of level/cmp/sat/debounce + flush
//   mode       in   2      00 CMP, 01 INTEG, 10 FOLLOW, 11 behaves as CMP
//   in_valid   in   1      sample valid
//   in_ready   out  1      sample accepted when in_valid & in_ready
//   vip        in   WIDTH  positive input (unsigned)
//   vin        in   WIDTH  negative input (unsigned)
//   out_valid  out  1      one-cycle pulse per accepted sample, latency 2
//   out_level  out  ACC_W  output-node level (signed)
//   out_cmp    out  1      debounced comparator output
//   sat        out  1      sticky rail-hit flag
// ============================================================================
module digi_ota_sampled_core
   import digi_ota_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int ACC_W    = DEF_ACC_W,
   parameter int GM_SHIFT = DEF_GM_SHIFT,
   parameter int HYST     = DEF_HYST,
   parameter int DEBOUNCE = DEF_DEBOUNCE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    clr,
   input  logic [1:0]              mode,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        vip,
   input  logic [WIDTH-1:0]        vin,
   output logic                    out_valid,
   output logic signed [ACC_W-1:0] out_level,
   output logic                    out_cmp,
   output logic                    sat
);

   // Two guard bits keep every intermediate sum free of wrap-around.
   localparam int                        c_ext_w = ACC_W + 2;
   localparam logic signed [c_ext_w-1:0] c_step  = c_ext_w'(2 ** GM_SHIFT);

   logic                    w_accept;
   mode_e                   w_mode_in;
   logic signed [WIDTH:0]   w_d_in;

   logic                    r_s1_valid;
   logic signed [WIDTH:0]   r_s1_d;
   mode_e                   r_s1_mode;

   logic                    r_s2_valid;
   logic signed [ACC_W-1:0] r_level;
   logic                    r_sat;
   mode_e                   r_prev_mode;

   logic signed [c_ext_w-1:0] w_d_ext;
   logic signed [c_ext_w-1:0] w_level_ext;
   logic signed [c_ext_w-1:0] w_diff;
   logic signed [c_ext_w-1:0] w_sum;
   logic signed [SAT_W-1:0]   w_sum_wide;
   logic signed [SAT_W-1:0]   w_sat_wide;
   logic signed [ACC_W-1:0]   w_level_nxt;
   logic                      w_clip;
   logic                      w_upd;
   logic                      w_mode_chg;

   // ---------------------------------------------------------------- input
   assign in_ready = en & ~clr;
   assign w_accept = in_valid & in_ready;
   assign w_d_in   = $signed({1'b0, vip}) - $signed({1'b0, vin});

   // The reserved encoding is folded onto CMP here so that it is also
   // treated as CMP by the mode-change detection further down.
   always_comb begin
      w_mode_in = MODE_CMP;
      case (mode)
         2'b01:   w_mode_in = MODE_INTEG;
         2'b10:   w_mode_in = MODE_FOLLOW;
         default: w_mode_in = MODE_CMP;
      endcase
   end

   // -------------------------------------------------------------- stage 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_d     <= '0;
         r_s1_mode  <= MODE_CMP;
      end else if (clr) begin
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_d    <= w_d_in;
            r_s1_mode <= w_mode_in;
         end
      end
   end

   // ------------------------------------------------------ level datapath
   assign w_d_ext     = {{(c_ext_w - WIDTH - 1){r_s1_d[WIDTH]}}, r_s1_d};
   assign w_level_ext = {{2{r_level[ACC_W-1]}}, r_level};

   always_comb begin
      w_diff = w_d_ext - w_level_ext;
      w_sum  = w_d_ext;
      case (r_s1_mode)
         MODE_INTEG: begin
            w_sum = w_level_ext + (w_d_ext >>> GM_SHIFT);
         end
         MODE_FOLLOW: begin
            // Step towards the input by at most c_step, landing exactly on it
            // once it is within reach.
            if (w_diff > c_step) begin
               w_sum = w_level_ext + c_step;
            end else if (w_diff < -c_step) begin
               w_sum = w_level_ext - c_step;
            end else begin
               w_sum = w_d_ext;
            end
         end
         default: begin
            w_sum = w_d_ext;
         end
      endcase
   end

   assign w_sum_wide  = {{(SAT_W - c_ext_w){w_sum[c_ext_w-1]}}, w_sum};
   assign w_sat_wide  = saturate(w_sum_wide, ACC_W);
   assign w_level_nxt = w_sat_wide[ACC_W-1:0];
   assign w_clip      = (w_sat_wide != w_sum_wide);

   assign w_upd      = r_s1_valid & ~clr;
   assign w_mode_chg = r_s1_valid & (r_s1_mode != r_prev_mode);

   // -------------------------------------------------------------- stage 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid  <= 1'b0;
         r_level     <= '0;
         r_sat       <= 1'b0;
         r_prev_mode <= MODE_CMP;
      end else if (clr) begin
         r_s2_valid <= 1'b0;
         r_level    <= '0;
         r_sat      <= 1'b0;
      end else begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_level     <= w_level_nxt;
            r_sat       <= r_sat | w_clip;
            r_prev_mode <= r_s1_mode;
         end
      end
   end

   digi_ota_hyst_cmp #(
      .ACC_W    (ACC_W),
      .HYST     (HYST),
      .DEBOUNCE (DEBOUNCE)
   ) u_hyst_cmp (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .upd      (w_upd),
      .mode_chg (w_mode_chg),
      .level    (w_level_nxt),
      .out_cmp  (out_cmp)
   );

   assign out_valid = r_s2_valid;
   assign out_level = r_level;
   assign sat       = r_sat;

endmodule
`default_nettype wire
